input_port_buffer: RTL

INPUT_PORT_BUFFER -- requirements
Module: input_port_buffer

---
 rtl/io_port_pkg.sv | 15 +
 rtl/io_port_ram.sv | 23 ++
 rtl/input_port_buffer.sv | 96 +++++++++
 3 files changed

// File: rtl/io_port_pkg.sv
// Shared definitions for the processor I/O port blocks: default widths,
// the byte type and the occupancy-counter width helper.
package io_port_pkg;

  localparam int DW_DEF    = 8;
  localparam int DEPTH_DEF = 8;

  typedef logic [DW_DEF-1:0] byte_t;

  // Occupancy must represent 0..depth inclusive, hence one extra bit.
  function automatic int level_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/io_port_ram.sv
// DEPTH x DW storage for the input port buffer: synchronous write,
// asynchronous read. Contents are deliberately not reset.
module io_port_ram #(
  parameter int DEPTH = 8,
  parameter int DW    = 8
) (
  input  logic                     clk,
  input  logic                     i_we,
  input  logic [$clog2(DEPTH)-1:0] i_waddr,
  input  logic [DW-1:0]            i_wdata,
  input  logic [$clog2(DEPTH)-1:0] i_raddr,
  output logic [DW-1:0]            o_rdata
);

  logic [DW-1:0] r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/input_port_buffer.sv
// Byte FIFO between an external device and the processor INPR/FGI input port.
// Optional registered interrupt output enabled by macro INPUT_PORT_IRQ_EN.
module input_port_buffer
  import io_port_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEF,
  parameter int DW    = DW_DEF
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [DW-1:0]                 dev_data,
  input  logic                          dev_valid,
  output logic                          dev_ready,
  output logic [DW-1:0]                 inpt,
  output logic                          fgi,
  input  logic                          load_INPR,
  output logic [level_width(DEPTH)-1:0] level,
  output logic                          ovf,
`ifdef INPUT_PORT_IRQ_EN
  input  logic                          irq_en,
  output logic                          irq,
`endif
  input  logic                          ovf_clr
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = level_width(DEPTH);
  localparam logic [LW-1:0] LVL_FULL = LW'(DEPTH);

  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [LW-1:0] r_level;
  logic          r_ovf;

  logic          w_push;
  logic          w_pop;
  logic          w_full;
  logic          w_ovf_evt;
  logic [DW-1:0] w_rd_data;

  assign w_full    = (r_level == LVL_FULL);
  assign dev_ready = (r_level < LVL_FULL);
  assign fgi       = (r_level != '0);
  assign w_push    = dev_valid && dev_ready;
  assign w_pop     = load_INPR && fgi;
  assign w_ovf_evt = dev_valid && w_full;

  // Pointers are AW bits wide so wrap modulo DEPTH comes for free.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
      r_ovf    <= 1'b0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + 1'b1;
        2'b01:   r_level <= r_level - 1'b1;
        default: r_level <= r_level;
      endcase
      // A fresh overflow wins over a coincident clear.
      if (w_ovf_evt)    r_ovf <= 1'b1;
      else if (ovf_clr) r_ovf <= 1'b0;
    end
  end

  io_port_ram #(
    .DEPTH (DEPTH),
    .DW    (DW)
  ) u_ram (
    .clk     (clk),
    .i_we    (w_push),
    .i_waddr (r_wr_ptr),
    .i_wdata (dev_data),
    .i_raddr (r_rd_ptr),
    .o_rdata (w_rd_data)
  );

  assign inpt  = fgi ? w_rd_data : '0;
  assign level = r_level;
  assign ovf   = r_ovf;

`ifdef INPUT_PORT_IRQ_EN
  logic r_irq;

  always_ff @(posedge clk) begin
    if (!rst) r_irq <= 1'b0;
    else      r_irq <= fgi && irq_en;
  end

  assign irq = r_irq;
`endif

endmodule
